fft_power_spectrum: RTL
=======================

# fft_power_spectrum

Post-FFT power stage of the MFCC pipeline. Started by the FFT network controller's end-of-FFT pulse, it streams the one-sided spectrum (bins 0..N/2) out of the real and imaginary FFT result memories. For each bin it computes P = re² + im² in IEEE-754 single precision and writes the result to the power-spectrum memory consumed by the Mel filter bank.

## Interface
Parameters:
- ADDR_WIDTH, 12: address width of the FFT result memories and the power memory.
- DATA_WIDTH, 32: sample width, IEEE-754 binary32. Fixed at 32.
- RD_LAT, 2: cycles from addr_rd presented to data_rd_real/data_rd_image valid.
- PIPE_LAT, 4: register stages inside the squared-magnitude datapath.

Ports:
- clk  in  1  clock. Rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena_mag  in  1  start pulse, driven by end_fft of the FFT network controller.
- max_point_fft  in  ADDR_WIDTH  FFT size N, a power of two. Latched at start.
- addr_rd  out  ADDR_WIDTH  shared read address for the real and imaginary result memories.
- data_rd_real  in  DATA_WIDTH  real part of X[k].
- data_rd_image  in  DATA_WIDTH  imaginary part of X[k].
- wr_ena_pow  out  1  power memory write enable.
- addr_pow  out  ADDR_WIDTH  power memory write address (bin index k).
- data_pow  out  DATA_WIDTH  |X[k]|² as binary32.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse after the last write.

## Operation
- NB = max_point_fft/2 + 1, computed from the latched N. For example, N=512 gives NB=257. NB is at most 2^(ADDR_WIDTH-1)+1, so no wrap can occur.
- FSM has four states:
  - IDLE: waits for ena_mag, then goes to READ.
  - READ: addr_rd counts 0..NB-1, one address per cycle. After NB-1 it goes to DRAIN.
  - DRAIN: waits until the valid pipeline is empty, then goes to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
- ena_mag is ignored outside IDLE.
- A valid/address shift register of depth RD_LAT+PIPE_LAT tracks each bin. wr_ena_pow is the tail valid bit; addr_pow is the tail address.
- Arithmetic in fp_sq_sum:
  - Squares are non-negative, so only positive addition is needed.
  - Squaring: 24×24 mantissa product, exponent 2e−127, normalize by at most 1, truncate to 23 fraction bits.
  - Sum: align the smaller operand by right shift (truncating), add, normalize by at most 1 right shift, truncate. No round-to-nearest.
  - Zero and denormal inputs are flushed to 0. Underflow of a square gives 0.
  - Exponent overflow or an infinite input gives +inf (0x7F800000).
  - Any NaN input gives 0x7FC00000. Sign bit of data_pow is always 0.
- Reset at any time returns the block to IDLE, clears the pipeline, and drives all outputs to 0. No partial-frame completion after reset.

## Timing
- Reset values: addr_rd=0, wr_ena_pow=0, addr_pow=0, data_pow=0, busy=0, done=0.
- Edge T0 samples ena_mag=1 in IDLE. After T0, busy=1 and addr_rd=0. addr_rd=k holds during cycle T0+1+k.
- The write for bin k occurs in cycle T0+1+k+RD_LAT+PIPE_LAT. Writes are contiguous, one per cycle.
- done=1 in the cycle after the last write, and busy falls on the same edge.
- Total frame latency from T0 to done is NB+RD_LAT+PIPE_LAT+1 cycles.
- An ena_mag arriving in the done cycle is ignored. The earliest accepted restart is the cycle after done.

## Configuration
- Macro POW_PEAK_EN.
- When defined: adds outputs peak_addr (ADDR_WIDTH) and peak_val (DATA_WIDTH).
  - Both clear at start.
  - The running maximum updates on every write. Comparison is unsigned on the raw binary32 bits, which is valid because all values are non-negative.
  - Ties keep the lower bin.
  - Both are stable from done until the next start.
- When undefined: neither port exists, and no comparator or extra registers are built.

## Structure
- Shared package mfcc_pkg holds the FSM state encoding and the constants FP_ZERO, FP_INF=0x7F800000, FP_QNAN=0x7FC00000, FP_BIAS=127.
- Sub-module fp_sq_sum is the PIPE_LAT-stage binary32 re²+im² datapath with no control logic. The top level holds the FSM, address counter, and valid pipeline.

## Test plan
- Single bin, N=8, bin 0 re=0x40400000 (3.0), im=0x40800000 (4.0) -> data_pow=0x41C80000 (25.0) at addr_pow=0.
- N=8 at default latencies -> exactly 5 writes to addrs 0..4 in cycles T0+7..T0+11, done in T0+12, busy high for T0+1..T0+11.
- Flush and identity cases:
  - re=0x3F800000, im=0 -> 0x3F800000.
  - re=0x00000001, im=0x80000000 -> 0x00000000.
- Overflow and NaN cases:
  - re=0x7F000000, im=0 -> 0x7F800000.
  - re=0x7FC00000 -> 0x7FC00000.
- ena_mag pulsed while busy -> no restart and same write count. rst_n low at bin 3 of N=64 -> all outputs 0 next cycle; new ena_mag starts a fresh frame at addr 0.
- POW_PEAK_EN, N=16, bins 2 and 5 both equal to 100.0, all others smaller -> peak_addr=2, peak_val=0x42C80000.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared MFCC pipeline definitions: FSM encoding, binary32 constants and
// the stage payloads of the squared-magnitude datapath.
package mfcc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int unsigned FP_BIAS    = 127;
    localparam int unsigned FP_EXP_MAX = 255;

    // Stage 1: classified operand and top 25 bits of the 48-bit mantissa square
    typedef struct packed {
        logic        nan;
        logic        inf;
        logic        zero;
        logic [7:0]  exp;
        logic [24:0] prod;
    } sq_raw_t;

    // Stage 2: normalised square, man includes the hidden bit (0 means zero)
    typedef struct packed {
        logic        nan;
        logic        inf;
        logic [7:0]  exp;
        logic [23:0] man;
    } sq_t;

    // Stage 3: aligned sum before final normalisation
    typedef struct packed {
        logic        nan;
        logic        inf;
        logic [7:0]  exp;
        logic [24:0] sum;
    } sum_t;

endpackage

// File: rtl/fft_power_spectrum_if.sv
// Memory-side bus of the power stage: FFT result read port and power write port.
interface fft_power_spectrum_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic [DATA_WIDTH-1:0] data_rd_real;
    logic [DATA_WIDTH-1:0] data_rd_image;
    logic                  wr_ena_pow;
    logic [ADDR_WIDTH-1:0] addr_pow;
    logic [DATA_WIDTH-1:0] data_pow;

    modport master (
        output addr_rd,
        input  data_rd_real,
        input  data_rd_image,
        output wr_ena_pow,
        output addr_pow,
        output data_pow
    );

    modport slave (
        input  addr_rd,
        output data_rd_real,
        output data_rd_image,
        input  wr_ena_pow,
        input  addr_pow,
        input  data_pow
    );
endinterface

// File: rtl/fp_sq_sum.sv
// PIPE_LAT-stage binary32 re^2 + im^2 (truncating, denormals flushed, sign dropped).
// Stages: decode+multiply, normalise squares, align+add, pack (+ optional delay).
module fp_sq_sum
    import mfcc_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] re,
    input  logic [31:0] im,
    output logic [31:0] pow
);
    localparam int unsigned TAIL = (PIPE_LAT > 4) ? PIPE_LAT - 3 : 1;

    // Classify the magnitude bits and square the 24-bit significand
    function automatic sq_raw_t decode_sq(input logic [30:0] x);
        sq_raw_t r;
        r.nan  = (&x[30:23]) & (|x[22:0]);
        r.inf  = (&x[30:23]) & ~(|x[22:0]);
        r.zero = ~(|x[30:23]);
        r.exp  = x[30:23];
        r.prod = 25'((48'({1'b1, x[22:0]}) * 48'({1'b1, x[22:0]})) >> 23);
        return r;
    endfunction

    // Exponent 2e-bias (+1 if the product carried), with underflow/overflow
    function automatic sq_t norm_sq(input sq_raw_t a);
        sq_t        r;
        logic [9:0] u;
        r     = '0;
        r.nan = a.nan;
        u     = {1'b0, a.exp, 1'b0} + {9'd0, a.prod[24]};
        if (!a.nan) begin
            if (a.inf || (u >= 10'(FP_BIAS + FP_EXP_MAX))) begin
                r.inf = 1'b1;
            end else if (!a.zero && (u > 10'(FP_BIAS))) begin
                r.exp = 8'(u - 10'(FP_BIAS));
                r.man = a.prod[24] ? a.prod[24:1] : a.prod[23:0];
            end
        end
        return r;
    endfunction

    // Align the smaller square by truncating right shift and add
    function automatic sum_t add_sq(input sq_t a, input sq_t b);
        sum_t        r;
        sq_t         big;
        sq_t         sml;
        logic [7:0]  diff;
        logic [23:0] aligned;
        if (a.exp >= b.exp) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        diff    = big.exp - sml.exp;
        aligned = (diff > 8'd23) ? 24'd0 : (sml.man >> diff);
        r.nan   = a.nan | b.nan;
        r.inf   = a.inf | b.inf;
        r.exp   = big.exp;
        r.sum   = {1'b0, big.man} + {1'b0, aligned};
        return r;
    endfunction

    // Normalise by at most one right shift and apply special-value overrides
    function automatic logic [31:0] pack_sum(input sum_t s);
        logic [31:0] r;
        r = FP_ZERO;
        if (s.nan) begin
            r = FP_QNAN;
        end else if (s.inf) begin
            r = FP_INF;
        end else if (s.sum[24]) begin
            if (s.exp == 8'd254) r = FP_INF;
            else                 r = {1'b0, s.exp + 8'd1, s.sum[23:1]};
        end else begin
            r = {1'b0, s.exp, s.sum[22:0]};
        end
        return r;
    endfunction

    sq_raw_t              s1_re;
    sq_raw_t              s1_im;
    sq_t                  s2_re;
    sq_t                  s2_im;
    sum_t                 s3;
    logic [TAIL-1:0][31:0] out_q;
    logic                 sign_unused;

    assign sign_unused = re[31] ^ im[31];

    // Datapath pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_re <= '0;
            s1_im <= '0;
            s2_re <= '0;
            s2_im <= '0;
            s3    <= '0;
            out_q <= '0;
        end else begin
            s1_re    <= decode_sq(re[30:0]);
            s1_im    <= decode_sq(im[30:0]);
            s2_re    <= norm_sq(s1_re);
            s2_im    <= norm_sq(s1_im);
            s3       <= add_sq(s2_re, s2_im);
            out_q[0] <= pack_sum(s3);
            for (int i = 1; i < int'(TAIL); i++) begin
                out_q[i] <= out_q[i-1];
            end
        end
    end

    assign pow = out_q[TAIL-1];

endmodule

// File: rtl/fft_power_spectrum.sv
// Post-FFT power stage: streams bins 0..N/2 out of the FFT result memories and
// writes |X[k]|^2 (binary32) to the power memory.
// Optional running peak tracker enabled by defining POW_PEAK_EN.
module fft_power_spectrum
    import mfcc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned PIPE_LAT   = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena_mag,
    input  logic [ADDR_WIDTH-1:0] max_point_fft,
    fft_power_spectrum_if.master  mem,
`ifdef POW_PEAK_EN
    output logic [ADDR_WIDTH-1:0] peak_addr,
    output logic [DATA_WIDTH-1:0] peak_val,
`endif
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned DEPTH = RD_LAT + PIPE_LAT;

    logic [1:0]                       state;
    logic [1:0]                       next_state;
    logic [ADDR_WIDTH-1:0]            last_addr;
    logic [ADDR_WIDTH-1:0]            addr_next_c;
    logic                             busy_next_c;
    logic                             done_next_c;
    logic                             drained_c;
    logic                             start_c;
    logic [DEPTH-1:0]                 vld;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0]            pow;
    logic                             n_lsb_unused;

    assign n_lsb_unused = max_point_fft[0];
    assign start_c      = (state == ST_IDLE) && ena_mag;
    assign drained_c    = ~(|vld[DEPTH-2:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state, next address and next status flags
    always_comb begin
        next_state  = state;
        addr_next_c = '0;
        busy_next_c = 1'b0;
        done_next_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ena_mag) next_state = ST_READ;
            end
            ST_READ: begin
                if (mem.addr_rd == last_addr) next_state = ST_DRAIN;
                else                          addr_next_c = mem.addr_rd + ADDR_WIDTH'(1);
            end
            ST_DRAIN: begin
                if (drained_c) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        busy_next_c = (next_state == ST_READ) || (next_state == ST_DRAIN);
        done_next_c = (next_state == ST_DONE);
    end

    // Registered read address, status flags and latched last bin index N/2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.addr_rd <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            last_addr   <= '0;
        end else begin
            mem.addr_rd <= addr_next_c;
            busy        <= busy_next_c;
            done        <= done_next_c;
            if (start_c) last_addr <= {1'b0, max_point_fft[ADDR_WIDTH-1:1]};
        end
    end

    // Valid/bin-index shift register covering memory and datapath latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            tag <= '0;
        end else begin
            vld <= {vld[DEPTH-2:0], (state == ST_READ)};
            tag <= {tag[DEPTH-2:0], mem.addr_rd};
        end
    end

    fp_sq_sum #(
        .PIPE_LAT (PIPE_LAT)
    ) u_sq_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (mem.data_rd_real),
        .im    (mem.data_rd_image),
        .pow   (pow)
    );

    assign mem.wr_ena_pow = vld[DEPTH-1];
    assign mem.addr_pow   = tag[DEPTH-1];
    assign mem.data_pow   = pow;

`ifdef POW_PEAK_EN
    // Running maximum over raw bits; strict compare keeps the lowest tied bin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_addr <= '0;
            peak_val  <= '0;
        end else if (start_c) begin
            peak_addr <= '0;
            peak_val  <= '0;
        end else if (vld[DEPTH-1] && (pow > peak_val)) begin
            peak_addr <= tag[DEPTH-1];
            peak_val  <= pow;
        end
    end
`endif

endmodule
